reaction_timer_core: RTL and testbench



---
 rtl/rt_pkg.sv | 30 +++
 rtl/reaction_timer_core_if.sv | 25 ++
 rtl/bcd_upcount.sv | 45 ++++
 rtl/reaction_timer_core.sv | 151 +++++++++++++++
 tb/tb_reaction_timer_core.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer core: FSM states, display codes, LFSR.
// No logic of its own beyond the combinational LFSR step function.
package rt_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_EARLY   = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        DISP_HI      = 3'd0,
        DISP_BLANK   = 3'd1,
        DISP_TIME    = 3'd2,
        DISP_EARLY   = 3'd3,
        DISP_TIMEOUT = 3'd4
    } disp_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_core_if.sv
// Button-tick inputs and display-side outputs of the reaction-timer core.
// master drives the ticks and level controls, slave is the core.
interface reaction_timer_core_if #(
    parameter int N_DIGITS = 4
);
    logic                  start_tick;
    logic                  stop_tick;
    logic                  clear_tick;
    logic                  show_best;
    logic [4*N_DIGITS-1:0] digits;
    logic [2:0]            disp_mode;
    logic                  led;
    logic                  busy;
    logic                  best_valid;

    modport master (
        output start_tick, stop_tick, clear_tick, show_best,
        input  digits, disp_mode, led, busy, best_valid
    );

    modport slave (
        input  start_tick, stop_tick, clear_tick, show_best,
        output digits, disp_mode, led, busy, best_valid
    );
endinterface

// File: rtl/bcd_upcount.sv
// Multi-digit BCD up-counter with synchronous clear; saturates at all 9s.
// q is registered; nxt exposes the value q takes at the next edge.
module bcd_upcount #(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*N_DIGITS-1:0] q,
    output logic [4*N_DIGITS-1:0] nxt,
    output logic                  all9
);
    localparam logic [4*N_DIGITS-1:0] ALL9 = {N_DIGITS{4'h9}};

    logic carry;

    assign all9 = (q == ALL9);

    always_comb begin
        nxt   = q;
        carry = inc & ~all9;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (q[4*i +: 4] == 4'd9) begin
                    nxt[4*i +: 4] = 4'd0;
                end else begin
                    nxt[4*i +: 4] = q[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        if (clr) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end
endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer: random arming delay, then BCD timing of the stop press, with early/timeout/best tracking.
// All outputs registered from next-state values, so they reflect a state on its first cycle; inputs are ticks, no backpressure.
module reaction_timer_core
    import rt_pkg::*;
#(
    parameter int CLK_HZ           = 100_000_000,
    parameter int TICK_HZ          = 1000,
    parameter int N_DIGITS         = 4,
    parameter int DELAY_MIN_TICKS  = 1000,
    parameter int DELAY_STEP_TICKS = 250
) (
    input  logic clk,
    input  logic rst,
    reaction_timer_core_if.slave io
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = $clog2(DELAY_MIN_TICKS + 15 * DELAY_STEP_TICKS + 1);
    localparam int BW  = 4 * N_DIGITS;
    localparam logic [BW-1:0] ALL9 = {N_DIGITS{4'h9}};

    if (DIV < 2) begin : g_div_chk
        $error("reaction_timer_core: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (DELAY_MIN_TICKS < 1) begin : g_delay_chk
        $error("reaction_timer_core: DELAY_MIN_TICKS must be at least 1");
    end

    state_t         state, state_nx;
    logic [PW-1:0]  presc;
    logic           tick;
    logic [7:0]     lfsr;
    logic [DW-1:0]  delay_cnt;
    logic [BW-1:0]  cnt_q, cnt_nx, best, best_nx, digits_nx;
    logic           cnt_clr, cnt_inc, cnt_all9;
    logic           best_ok, best_ok_nx, best_upd;
    disp_t          disp_nx;

    assign tick = (presc == PW'(DIV - 1));

    bcd_upcount #(.N_DIGITS(N_DIGITS)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .q    (cnt_q),
        .nxt  (cnt_nx),
        .all9 (cnt_all9)
    );

    // Clear beats stop beats start in every state.
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        if (io.clear_tick) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (!io.stop_tick && io.start_tick) state_nx = S_WAIT;
                end
                S_WAIT: begin
                    if (io.stop_tick) begin
                        state_nx = S_EARLY;
                    end else if (tick && delay_cnt == DW'(1)) begin
                        state_nx = S_RUN;
                        cnt_clr  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (io.stop_tick) begin
                        state_nx = S_DONE;
                    end else if (tick) begin
                        if (cnt_all9) state_nx = S_TIMEOUT;
                        else          cnt_inc  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign best_upd   = (state == S_RUN) && (state_nx == S_DONE) && (!best_ok || cnt_q < best);
    assign best_nx    = best_upd ? cnt_q : best;
    assign best_ok_nx = best_ok | best_upd;

    always_comb begin
        digits_nx = '0;
        disp_nx   = DISP_HI;
        case (state_nx)
            S_IDLE: begin
                if (io.show_best) begin
                    disp_nx   = DISP_TIME;
                    digits_nx = best_nx;
                end
            end
            S_WAIT:    disp_nx = DISP_BLANK;
            S_RUN: begin
                disp_nx   = DISP_TIME;
                digits_nx = cnt_nx;
            end
            S_DONE: begin
                disp_nx   = DISP_TIME;
                digits_nx = io.show_best ? best_nx : cnt_nx;
            end
            S_EARLY: begin
                disp_nx   = DISP_EARLY;
                digits_nx = ALL9;
            end
            S_TIMEOUT: begin
                disp_nx   = DISP_TIMEOUT;
                digits_nx = cnt_nx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            presc         <= '0;
            lfsr          <= LFSR_SEED;
            delay_cnt     <= '0;
            best          <= ALL9;
            best_ok       <= 1'b0;
            io.digits     <= '0;
            io.disp_mode  <= DISP_HI;
            io.led        <= 1'b0;
            io.busy       <= 1'b0;
            io.best_valid <= 1'b0;
        end else begin
            state <= state_nx;
            lfsr  <= lfsr_next(lfsr);
            // Restart the prescaler on entry so every state sees a full first tick period.
            if (state_nx != state || tick) presc <= '0;
            else                           presc <= presc + PW'(1);
            if (state_nx == S_WAIT && state != S_WAIT)
                delay_cnt <= DW'(DELAY_MIN_TICKS + DELAY_STEP_TICKS * int'(lfsr[3:0]));
            else if (state == S_WAIT && tick)
                delay_cnt <= delay_cnt - DW'(1);
            best          <= best_nx;
            best_ok       <= best_ok_nx;
            io.digits     <= digits_nx;
            io.disp_mode  <= disp_nx;
            io.led        <= (state_nx == S_RUN);
            io.busy       <= (state_nx == S_WAIT) || (state_nx == S_RUN);
            io.best_valid <= best_ok_nx;
        end
    end
endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench: 10 cycles per tick, delay = 2 + r ticks; a 2-digit instance covers timeout.
module tb_reaction_timer_core;
    import rt_pkg::*;

    localparam int DIV   = 10;
    localparam int DMIN  = 2;
    localparam int DSTEP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reaction_timer_core_if #(.N_DIGITS(4)) bus4 ();
    reaction_timer_core_if #(.N_DIGITS(2)) bus2 ();

    reaction_timer_core #(
        .CLK_HZ(10), .TICK_HZ(1), .N_DIGITS(4), .DELAY_MIN_TICKS(DMIN), .DELAY_STEP_TICKS(DSTEP)
    ) dut4 (.clk(clk), .rst(rst), .io(bus4));

    reaction_timer_core #(
        .CLK_HZ(10), .TICK_HZ(1), .N_DIGITS(2), .DELAY_MIN_TICKS(DMIN), .DELAY_STEP_TICKS(DSTEP)
    ) dut2 (.clk(clk), .rst(rst), .io(bus2));

    int errors = 0;
    int checks = 0;

    // Reference state: LFSR sequence from the seed, best time as a plain integer.
    logic [7:0] m_lfsr;
    int         m_best = 9999;
    bit         m_best_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'h01;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [15:0] bcd4(input int v);
        logic [15:0] b;
        int x;
        b = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return b;
    endfunction

    task automatic test_reset();
        bus4.start_tick = 0; bus4.stop_tick = 0; bus4.clear_tick = 0; bus4.show_best = 0;
        bus2.start_tick = 0; bus2.stop_tick = 0; bus2.clear_tick = 0; bus2.show_best = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus4.disp_mode !== DISP_HI || bus4.digits !== 16'h0000) begin
            errors++; $display("FAIL reset_disp: got mode=%0d digits=%h want mode=0 digits=0000", bus4.disp_mode, bus4.digits);
        end
        checks++;
        if (bus4.led !== 1'b0 || bus4.busy !== 1'b0 || bus4.best_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got led=%b busy=%b bv=%b want 0 0 0", bus4.led, bus4.busy, bus4.best_valid);
        end
        checks++;
        if (bus2.disp_mode !== DISP_HI || bus2.digits !== 8'h00 || bus2.busy !== 1'b0) begin
            errors++; $display("FAIL reset_dut2: got mode=%0d digits=%h busy=%b", bus2.disp_mode, bus2.digits, bus2.busy);
        end
        rst = 1'b0;
        m_best = 9999;
        m_best_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One full trial on the 4-digit core: start, measure arming, stop m cycles into RUN.
    task automatic test_trial(input int m, input string tag);
        int r, wc, t;
        @(negedge clk);
        r = int'(m_lfsr[3:0]);
        bus4.start_tick = 1'b1;
        @(negedge clk);
        bus4.start_tick = 1'b0;
        checks++;
        if (bus4.busy !== 1'b1 || bus4.disp_mode !== DISP_BLANK || bus4.led !== 1'b0) begin
            errors++; $display("FAIL %s wait_entry: got busy=%b mode=%0d led=%b want 1 1 0", tag, bus4.busy, bus4.disp_mode, bus4.led);
        end
        wc = 0;
        while (bus4.led !== 1'b1 && wc < 400) begin
            wc++;
            @(negedge clk);
        end
        checks++;
        if (wc != (DMIN + r * DSTEP) * DIV) begin
            errors++; $display("FAIL %s wait_len: got %0d cycles want %0d (r=%0d)", tag, wc, (DMIN + r * DSTEP) * DIV, r);
        end
        repeat (m) @(negedge clk);
        bus4.stop_tick = 1'b1;
        @(negedge clk);
        bus4.stop_tick = 1'b0;
        t = m / DIV;
        if (!m_best_valid || t < m_best) begin
            m_best = t;
            m_best_valid = 1'b1;
        end
        checks++;
        if (bus4.digits !== bcd4(t)) begin
            errors++; $display("FAIL %s done_time: got %h want %h", tag, bus4.digits, bcd4(t));
        end
        checks++;
        if (bus4.led !== 1'b0 || bus4.busy !== 1'b0 || bus4.best_valid !== 1'b1 || bus4.disp_mode !== DISP_TIME) begin
            errors++; $display("FAIL %s done_flags: got led=%b busy=%b bv=%b mode=%0d want 0 0 1 2",
                               tag, bus4.led, bus4.busy, bus4.best_valid, bus4.disp_mode);
        end
        bus4.show_best = 1'b1;
        @(negedge clk);
        checks++;
        if (bus4.digits !== bcd4(m_best)) begin
            errors++; $display("FAIL %s best: got %h want %h", tag, bus4.digits, bcd4(m_best));
        end
        bus4.show_best = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early();
        @(negedge clk);
        bus4.start_tick = 1'b1;
        @(negedge clk);
        bus4.start_tick = 1'b0;
        bus4.stop_tick  = 1'b1;
        @(negedge clk);
        bus4.stop_tick  = 1'b0;
        checks++;
        if (bus4.disp_mode !== DISP_EARLY || bus4.digits !== 16'h9999 || bus4.led !== 1'b0) begin
            errors++; $display("FAIL early: got mode=%0d digits=%h led=%b want 3 9999 0", bus4.disp_mode, bus4.digits, bus4.led);
        end
        bus4.start_tick = 1'b1;
        @(negedge clk);
        bus4.start_tick = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus4.disp_mode !== DISP_EARLY || bus4.busy !== 1'b0) begin
            errors++; $display("FAIL early_start_ignored: got mode=%0d busy=%b want 3 0", bus4.disp_mode, bus4.busy);
        end
        bus4.clear_tick = 1'b1;
        @(negedge clk);
        bus4.clear_tick = 1'b0;
        checks++;
        if (bus4.disp_mode !== DISP_HI || bus4.busy !== 1'b0) begin
            errors++; $display("FAIL early_clear: got mode=%0d busy=%b want 0 0", bus4.disp_mode, bus4.busy);
        end
    endtask

    task automatic test_clear_in_wait();
        @(negedge clk);
        bus4.start_tick = 1'b1;
        @(negedge clk);
        bus4.start_tick = 1'b0;
        repeat ($urandom_range(1, 15)) @(negedge clk);
        bus4.clear_tick = 1'b1;
        bus4.stop_tick  = 1'b1;
        @(negedge clk);
        bus4.clear_tick = 1'b0;
        bus4.stop_tick  = 1'b0;
        checks++;
        if (bus4.disp_mode !== DISP_HI || bus4.busy !== 1'b0 || bus4.led !== 1'b0) begin
            errors++; $display("FAIL clear_stop_wait: got mode=%0d busy=%b led=%b want 0 0 0", bus4.disp_mode, bus4.busy, bus4.led);
        end
        bus4.show_best = 1'b1;
        @(negedge clk);
        checks++;
        if (bus4.disp_mode !== DISP_TIME || bus4.digits !== bcd4(m_best)) begin
            errors++; $display("FAIL idle_show_best: got mode=%0d digits=%h want 2 %h", bus4.disp_mode, bus4.digits, bcd4(m_best));
        end
        bus4.show_best = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int r, wc, tc;
        @(negedge clk);
        r = int'(m_lfsr[3:0]);
        bus2.start_tick = 1'b1;
        @(negedge clk);
        bus2.start_tick = 1'b0;
        wc = 0;
        while (bus2.led !== 1'b1 && wc < 400) begin
            wc++;
            @(negedge clk);
        end
        checks++;
        if (wc != (DMIN + r * DSTEP) * DIV) begin
            errors++; $display("FAIL to_wait_len: got %0d want %0d", wc, (DMIN + r * DSTEP) * DIV);
        end
        tc = 0;
        while (bus2.disp_mode !== DISP_TIMEOUT && tc < 1100) begin
            if (tc == 425) begin
                checks++;
                if (bus2.digits !== 8'h42) begin
                    errors++; $display("FAIL to_live_count: got %h want 42", bus2.digits);
                end
            end
            @(negedge clk);
            tc++;
        end
        checks++;
        if (tc != 100 * DIV) begin
            errors++; $display("FAIL to_run_len: got %0d cycles want %0d", tc, 100 * DIV);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (bus2.disp_mode !== DISP_TIMEOUT || bus2.digits !== 8'h99 || bus2.best_valid !== 1'b0 || bus2.led !== 1'b0) begin
            errors++; $display("FAIL timeout_hold: got mode=%0d digits=%h bv=%b led=%b want 4 99 0 0",
                               bus2.disp_mode, bus2.digits, bus2.best_valid, bus2.led);
        end
    endtask

    task automatic test_reset_mid_run();
        int wc;
        @(negedge clk);
        bus4.start_tick = 1'b1;
        @(negedge clk);
        bus4.start_tick = 1'b0;
        wc = 0;
        while (bus4.led !== 1'b1 && wc < 400) begin
            wc++;
            @(negedge clk);
        end
        repeat (13) @(negedge clk);
        checks++;
        if (bus4.led !== 1'b1 || bus4.digits !== 16'h0001) begin
            errors++; $display("FAIL pre_reset_run: got led=%b digits=%h want 1 0001", bus4.led, bus4.digits);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus4.disp_mode !== DISP_HI || bus4.digits !== 16'h0000 || bus4.led !== 1'b0 ||
            bus4.busy !== 1'b0 || bus4.best_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_run: got mode=%0d digits=%h led=%b busy=%b bv=%b want 0 0000 0 0 0",
                               bus4.disp_mode, bus4.digits, bus4.led, bus4.busy, bus4.best_valid);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_trial(37, "trial1");
        test_trial(55, "trial2");
        test_trial(24, "trial3");
        for (int i = 0; i < 3; i++) begin
            test_trial(int'($urandom_range(0, 150)), "random");
        end
        test_trial(39, "stop_on_tick");
        test_early();
        test_clear_in_wait();
        test_timeout();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
